ahbl_apb_bridge_n: RTL and testbench



---
 rtl/ahbl_apb_bridge_n.sv | 200 ++++++++++++++++++++
 tb/tb_ahbl_apb_bridge_n.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_apb_bridge_n.sv
// AHB-Lite slave to APB3 master bridge that decodes one AHB slot into up to 16 APB slaves.
// Optional ACCESS-phase timeout is compiled in with `define AHBL_APB_BRIDGE_TIMEOUT_EN.
module ahbl_apb_bridge_n #(
  parameter int ADDR_W         = 32,
  parameter int NUM_SLAVES     = 16,
  parameter int SLOT_LSB       = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     HCLK,
  input  logic                     HRESETN,
  input  logic                     HSEL,
  input  logic [ADDR_W-1:0]        HADDR,
  input  logic                     HWRITE,
  input  logic [1:0]               HTRANS,
  input  logic [31:0]              HWDATA,
  input  logic                     HREADYIN,
  output logic                     HREADYOUT,
  output logic [31:0]              HRDATA,
  output logic                     HRESP,
  output logic [NUM_SLAVES-1:0]    PSEL,
  output logic [ADDR_W-1:0]        PADDR,
  output logic                     PWRITE,
  output logic                     PENABLE,
  output logic [31:0]              PWDATA,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY,
  input  logic [NUM_SLAVES-1:0]    PSLVERR
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic [ADDR_W-1:0]       paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic                    penable_q, penable_d;
  logic [31:0]             pwdata_q, pwdata_d;
  logic [31:0]             hrdata_q, hrdata_d;
  logic                    hreadyout_q, hreadyout_d;
  logic                    hresp_q, hresp_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;

  logic [3:0]              hslot;
  logic                    hslot_mapped;
  logic                    accept;
  logic [NUM_SLAVES-1:0]   slot_onehot;
  logic                    pready_sel;
  logic                    pslverr_sel;
  logic [31:0]             prdata_sel;
  logic                    timed_out;
  logic                    unused_htrans0;

  assign unused_htrans0 = HTRANS[0];
  assign hslot          = HADDR[SLOT_LSB +: 4];
  assign hslot_mapped   = ({1'b0, hslot} < 5'(NUM_SLAVES));
  assign accept         = HSEL && HREADYIN && HTRANS[1] &&
                          (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR2);

  // Per-slave response mux driven by the captured index
  always_comb begin
    slot_onehot = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == 4'(i)) begin
        slot_onehot[i] = 1'b1;
        pready_sel     = PREADY[i];
        pslverr_sel    = PSLVERR[i];
        prdata_sel     = PRDATA[32*i +: 32];
      end
    end
  end

`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_SETUP) begin
      tmo_cnt_d = '0;
    end else if (state_q == S_ACCESS && !pready_sel) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th stalled ACCESS cycle; a PREADY in that cycle still wins
  assign timed_out = (state_q == S_ACCESS) && !pready_sel &&
                     (tmo_cnt_q >= 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          idx_d = hslot;
          if (hslot_mapped) begin
            paddr_d  = HADDR;
            pwrite_d = HWRITE;
            state_d  = S_LATCH;
          end else begin
            state_d  = S_ERR1;
          end
        end
      end
      S_LATCH: begin
        if (pwrite_q) begin
          pwdata_d = HWDATA;
        end
        state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_sel) begin
          if (pslverr_sel) begin
            state_d = S_ERR1;
          end else begin
            state_d = S_DONE;
            if (!pwrite_q) begin
              hrdata_d = prdata_sel;
            end
          end
        end else if (timed_out) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus outputs are registered copies decoded from the next state
    hreadyout_d = (state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR2);
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
    penable_d   = (state_d == S_ACCESS);
    psel_d      = (state_d == S_SETUP || state_d == S_ACCESS) ? slot_onehot : '0;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      pwdata_q    <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      psel_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      penable_q   <= penable_d;
      pwdata_q    <= pwdata_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      psel_q      <= psel_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRDATA    = hrdata_q;
  assign HRESP     = hresp_q;
  assign PSEL      = psel_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PENABLE   = penable_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahbl_apb_bridge_n.sv
// Directed bench for ahbl_apb_bridge_n: cycle table on a 16-slave bridge plus
// hand sequences for unmapped slots on a 4-slave bridge and the ACCESS timeout.
module tb_ahbl_apb_bridge_n;

  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_NSEQ = 2'b10;

  logic        clk;
  logic        hresetn, hsel, hsel_s, hwrite, hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr, hwdata;
  logic [15:0] pready, pslverr;
  logic [31:0] pr_word;
  logic [511:0] prdata_bus;

  logic        hreadyout, hresp, pwrite, penable;
  logic [31:0] hrdata, paddr, pwdata;
  logic [15:0] psel;

  logic        s_hreadyout, s_hresp, s_pwrite, s_penable;
  logic [31:0] s_hrdata, s_paddr, s_pwdata;
  logic [3:0]  s_psel;
  logic [127:0] s_prdata;

  int tests = 0;
  int fails = 0;

  assign prdata_bus = {16{pr_word}};
  assign s_prdata   = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ahbl_apb_bridge_n #(.ADDR_W(32), .NUM_SLAVES(16), .SLOT_LSB(8), .TIMEOUT_CYCLES(8)) dut (
    .HCLK(clk), .HRESETN(hresetn), .HSEL(hsel), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HWDATA(hwdata), .HREADYIN(hreadyin), .HREADYOUT(hreadyout),
    .HRDATA(hrdata), .HRESP(hresp), .PSEL(psel), .PADDR(paddr), .PWRITE(pwrite),
    .PENABLE(penable), .PWDATA(pwdata), .PRDATA(prdata_bus), .PREADY(pready),
    .PSLVERR(pslverr)
  );

  ahbl_apb_bridge_n #(.ADDR_W(32), .NUM_SLAVES(4), .SLOT_LSB(8), .TIMEOUT_CYCLES(8)) u_small (
    .HCLK(clk), .HRESETN(hresetn), .HSEL(hsel_s), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HWDATA(hwdata), .HREADYIN(hreadyin), .HREADYOUT(s_hreadyout),
    .HRDATA(s_hrdata), .HRESP(s_hresp), .PSEL(s_psel), .PADDR(s_paddr), .PWRITE(s_pwrite),
    .PENABLE(s_penable), .PWDATA(s_pwdata), .PRDATA(s_prdata), .PREADY(4'hF),
    .PSLVERR(4'h0)
  );

  typedef struct {
    logic        rstn, sel, rdyin, wr;
    logic [1:0]  tr;
    logic [31:0] addr, wd;
    logic [15:0] prdy, perr;
    logic [31:0] prd;
    logic        e_hr, e_resp, e_pen, e_pwr;
    logic [15:0] e_psel;
    logic [31:0] e_paddr, e_pwd, e_hrd;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic r, input logic s, input logic ri, input logic [1:0] t,
                     input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [15:0] py, input logic [15:0] pe, input logic [31:0] pd,
                     input logic ehr, input logic ers, input logic [15:0] eps, input logic epe,
                     input logic [31:0] epa, input logic epw, input logic [31:0] epd,
                     input logic [31:0] ehd);
    vec_t v;
    v.rstn = r; v.sel = s; v.rdyin = ri; v.tr = t; v.addr = a; v.wr = w; v.wd = d;
    v.prdy = py; v.perr = pe; v.prd = pd;
    v.e_hr = ehr; v.e_resp = ers; v.e_psel = eps; v.e_pen = epe;
    v.e_paddr = epa; v.e_pwr = epw; v.e_pwd = epd; v.e_hrd = ehd;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic go_idle();
    hsel = 1'b0; hsel_s = 1'b0; htrans = TR_IDLE; haddr = '0; hwrite = 1'b0;
  endtask

  // Drives one transfer to slave 5 and counts ACCESS cycles until it ends.
  task automatic run_stall(input int ready_at, output int acc, output logic ended);
    acc = 0; ended = 1'b0; pready = '0; pslverr = '0;
    @(negedge clk);
    hsel = 1'b1; htrans = TR_NSEQ; haddr = 32'h0000_0500; hwrite = 1'b0;
    tick();
    go_idle();
    for (int c = 0; c < 40; c++) begin
      tick();
      if (penable) begin
        acc++;
        pready = (acc == ready_at) ? 16'h0020 : 16'h0000;
      end else if (hresp || hreadyout) begin
        ended = 1'b1;
        break;
      end
    end
    pready = '0;
  endtask

  localparam logic [31:0] C = 32'hCAFEF00D;
  localparam logic [31:0] H = 32'h12345678;
  localparam logic [31:0] W1 = 32'h11111111;
  localparam logic [31:0] W2 = 32'h22222222;

  initial begin
    int   acc;
    logic ended;

    hresetn = 1'b0; hreadyin = 1'b1; hwdata = '0; pready = '0; pslverr = '0; pr_word = '0;
    go_idle();

    // reset state, then reset in the middle of a stalled ACCESS to slave 4
    row(0,0,1,TR_IDLE,0,0,0,0,0,0,                              1,0,16'h0000,0,0,0,0,0);
    row(1,1,1,TR_NSEQ,32'h400,1,0,0,0,0,                        0,0,16'h0000,0,32'h400,1,0,0);
    row(1,0,1,TR_IDLE,0,0,32'h55AA55AA,0,0,0,                   0,0,16'h0010,0,32'h400,1,32'h55AA55AA,0);
    row(1,0,1,TR_IDLE,0,0,0,0,0,0,                              0,0,16'h0010,1,32'h400,1,32'h55AA55AA,0);
    row(1,0,1,TR_IDLE,0,0,0,16'hFFEF,0,0,                       0,0,16'h0010,1,32'h400,1,32'h55AA55AA,0);
    row(0,0,1,TR_IDLE,0,0,0,0,0,0,                              1,0,16'h0000,0,0,0,0,0);
    // zero-wait write to slave 3
    row(1,1,1,TR_NSEQ,32'h304,1,0,0,0,0,                        0,0,16'h0000,0,32'h304,1,0,0);
    row(1,0,1,TR_IDLE,0,0,C,0,0,0,                              0,0,16'h0008,0,32'h304,1,C,0);
    row(1,0,1,TR_IDLE,0,0,0,0,0,0,                              0,0,16'h0008,1,32'h304,1,C,0);
    row(1,0,1,TR_IDLE,0,0,0,16'hFFFF,0,0,                       1,0,16'h0000,0,32'h304,1,C,0);
    row(1,0,1,TR_IDLE,0,0,0,0,0,0,                              1,0,16'h0000,0,32'h304,1,C,0);
    // BUSY, HSEL low and HREADYIN low must not start a transfer
    row(1,1,1,TR_BUSY,32'h100,0,0,0,0,0,                        1,0,16'h0000,0,32'h304,1,C,0);
    row(1,0,1,TR_NSEQ,32'h100,0,0,0,0,0,                        1,0,16'h0000,0,32'h304,1,C,0);
    row(1,1,0,TR_NSEQ,32'h100,0,0,0,0,0,                        1,0,16'h0000,0,32'h304,1,C,0);
    // read slave 1 with three wait states; other slaves ready to catch a bad mux
    row(1,1,1,TR_NSEQ,32'h100,0,0,0,0,0,                        0,0,16'h0000,0,32'h100,0,C,0);
    row(1,0,1,TR_IDLE,0,0,32'hDEADBEEF,0,0,0,                   0,0,16'h0002,0,32'h100,0,C,0);
    row(1,0,1,TR_IDLE,0,0,0,0,0,0,                              0,0,16'h0002,1,32'h100,0,C,0);
    for (int k = 0; k < 3; k++)
      row(1,0,1,TR_IDLE,0,0,0,16'hFFFD,0,32'hBAD0BAD0,          0,0,16'h0002,1,32'h100,0,C,0);
    row(1,0,1,TR_IDLE,0,0,0,16'h0002,0,H,                       1,0,16'h0000,0,32'h100,0,C,H);
    row(1,0,1,TR_IDLE,0,0,0,0,0,0,                              1,0,16'h0000,0,32'h100,0,C,H);
    // read slave 2 ending in PSLVERR; PSLVERR during a wait is ignored
    row(1,1,1,TR_NSEQ,32'h200,0,0,0,0,0,                        0,0,16'h0000,0,32'h200,0,C,H);
    row(1,0,1,TR_IDLE,0,0,0,0,0,0,                              0,0,16'h0004,0,32'h200,0,C,H);
    row(1,0,1,TR_IDLE,0,0,0,0,0,0,                              0,0,16'h0004,1,32'h200,0,C,H);
    row(1,0,1,TR_IDLE,0,0,0,16'hFFFB,16'h0004,0,                0,0,16'h0004,1,32'h200,0,C,H);
    row(1,0,1,TR_IDLE,0,0,0,16'h0004,16'h0004,32'hAAAA5555,     0,1,16'h0000,0,32'h200,0,C,H);
    row(1,0,1,TR_IDLE,0,0,0,0,0,0,                              1,1,16'h0000,0,32'h200,0,C,H);
    row(1,0,1,TR_IDLE,0,0,0,0,0,0,                              1,0,16'h0000,0,32'h200,0,C,H);
    // back-to-back writes to slave 0 then slave 15
    row(1,1,1,TR_NSEQ,32'h000,1,0,0,0,0,                        0,0,16'h0000,0,32'h000,1,C,H);
    row(1,0,1,TR_IDLE,0,0,W1,0,0,0,                             0,0,16'h0001,0,32'h000,1,W1,H);
    row(1,0,1,TR_IDLE,0,0,0,0,0,0,                              0,0,16'h0001,1,32'h000,1,W1,H);
    row(1,0,1,TR_IDLE,0,0,0,16'h0001,0,0,                       1,0,16'h0000,0,32'h000,1,W1,H);
    row(1,1,1,TR_NSEQ,32'hF00,1,0,0,0,0,                        0,0,16'h0000,0,32'hF00,1,W1,H);
    row(1,0,1,TR_IDLE,0,0,W2,0,0,0,                             0,0,16'h8000,0,32'hF00,1,W2,H);
    row(1,0,1,TR_IDLE,0,0,0,0,0,0,                              0,0,16'h8000,1,32'hF00,1,W2,H);
    row(1,0,1,TR_IDLE,0,0,0,16'h8000,0,0,                       1,0,16'h0000,0,32'hF00,1,W2,H);
    row(1,0,1,TR_IDLE,0,0,0,0,0,0,                              1,0,16'h0000,0,32'hF00,1,W2,H);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      hresetn = tbl[i].rstn; hsel = tbl[i].sel; hreadyin = tbl[i].rdyin; htrans = tbl[i].tr;
      haddr = tbl[i].addr; hwrite = tbl[i].wr; hwdata = tbl[i].wd;
      pready = tbl[i].prdy; pslverr = tbl[i].perr; pr_word = tbl[i].prd;
      tick();
      tests++;
      if (hreadyout !== tbl[i].e_hr || hresp !== tbl[i].e_resp || psel !== tbl[i].e_psel ||
          penable !== tbl[i].e_pen || paddr !== tbl[i].e_paddr || pwrite !== tbl[i].e_pwr ||
          pwdata !== tbl[i].e_pwd || hrdata !== tbl[i].e_hrd) begin
        fails++;
        $display("FAIL row%0d: got rdy=%b resp=%b psel=%h pen=%b paddr=%h pwr=%b pwd=%h hrd=%h want rdy=%b resp=%b psel=%h pen=%b paddr=%h pwr=%b pwd=%h hrd=%h",
                 i, hreadyout, hresp, psel, penable, paddr, pwrite, pwdata, hrdata,
                 tbl[i].e_hr, tbl[i].e_resp, tbl[i].e_psel, tbl[i].e_pen, tbl[i].e_paddr,
                 tbl[i].e_pwr, tbl[i].e_pwd, tbl[i].e_hrd);
      end
    end

    // unmapped slot 5 on a 4-slave bridge: ERR1 then ERR2, no PSEL
    @(negedge clk);
    go_idle(); pready = '0; pslverr = '0;
    hsel_s = 1'b1; htrans = TR_NSEQ; haddr = 32'h0000_0500;
    tick();
    chk("unmap_err1_rdy", {31'd0, s_hreadyout}, 32'd0);
    chk("unmap_err1_resp", {31'd0, s_hresp}, 32'd1);
    chk("unmap_err1_psel", {28'd0, s_psel}, 32'd0);
    tick();
    chk("unmap_err2_rdy", {31'd0, s_hreadyout}, 32'd1);
    chk("unmap_err2_resp", {31'd0, s_hresp}, 32'd1);
    chk("unmap_err2_psel", {28'd0, s_psel}, 32'd0);
    // still requesting in ERR2: accepted, straight back to ERR1
    tick();
    chk("err2_accept_rdy", {31'd0, s_hreadyout}, 32'd0);
    chk("err2_accept_resp", {31'd0, s_hresp}, 32'd1);
    go_idle();
    tick();
    tick();
    chk("unmap_idle_resp", {31'd0, s_hresp}, 32'd0);
    chk("unmap_idle_rdy", {31'd0, s_hreadyout}, 32'd1);

    // highest mapped slot (3) on the 4-slave bridge completes normally
    @(negedge clk);
    hsel_s = 1'b1; htrans = TR_NSEQ; haddr = 32'h0000_0300; hwrite = 1'b0;
    tick();
    go_idle();
    chk("slot3_latch_resp", {31'd0, s_hresp}, 32'd0);
    tick();
    chk("slot3_setup_psel", {28'd0, s_psel}, 32'h8);
    tick();
    chk("slot3_access_pen", {31'd0, s_penable}, 32'd1);
    tick();
    chk("slot3_done_rdy", {31'd0, s_hreadyout}, 32'd1);
    chk("slot3_done_hrdata", s_hrdata, 32'h33333333);

`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
    // PREADY stuck low: 8 ACCESS cycles then ERROR
    run_stall(0, acc, ended);
    chk("tmo_ended", {31'd0, ended}, 32'd1);
    chk("tmo_access_cycles", acc, 32'd8);
    chk("tmo_err1_resp", {31'd0, hresp}, 32'd1);
    chk("tmo_err1_rdy", {31'd0, hreadyout}, 32'd0);
    chk("tmo_err1_psel", {16'd0, psel}, 32'd0);
    tick();
    chk("tmo_err2_rdy", {31'd0, hreadyout}, 32'd1);
    chk("tmo_err2_resp", {31'd0, hresp}, 32'd1);
    tick();
    chk("tmo_idle_resp", {31'd0, hresp}, 32'd0);
    // PREADY in the last allowed cycle wins over the timeout
    run_stall(8, acc, ended);
    chk("tmo_race_ended", {31'd0, ended}, 32'd1);
    chk("tmo_race_cycles", acc, 32'd8);
    chk("tmo_race_resp", {31'd0, hresp}, 32'd0);
    chk("tmo_race_rdy", {31'd0, hreadyout}, 32'd1);
`else
    // without the timeout a long stall simply completes when PREADY comes
    run_stall(30, acc, ended);
    chk("stall_ended", {31'd0, ended}, 32'd1);
    chk("stall_access_cycles", acc, 32'd30);
    chk("stall_done_resp", {31'd0, hresp}, 32'd0);
    chk("stall_done_rdy", {31'd0, hreadyout}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
